// File: rtl/sdpb_pkg.sv
// ----------------------------------------------------------------------------
// sdpb_pkg
// Shared types for the SDPB pixel packing path.
//   rgb_t        : one 24-bit pixel, {r,g,b}, r in the upper byte
//   wr_state_e   : port-A write burst sequencer states
//   CH_PER_GROUP : channel words written per 16-pixel group (R, G, B)
// ----------------------------------------------------------------------------
package sdpb_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR_R = 2'd1,
    WR_G = 2'd2,
    WR_B = 2'd3
  } wr_state_e;

  localparam int CH_PER_GROUP = 3;

endpackage

// File: rtl/sdpb_pixel_packer.sv
// ----------------------------------------------------------------------------
// sdpb_pixel_packer
// Upstream stage of the SDPB double buffer. Collects 16 RGB pixels, splits them
// into three 128-bit channel words (R, G, B) and writes those words to SDPB
// port A on three consecutive cycles. buf_full pulses with the write to the
// last buffer address so the swap logic can flip buffers.
//
// Ports
//   clk         in   single clock (also SDPB clka)
//   resetn      in   asynchronous active-low reset
//   frame_start in   1-cycle pulse: restart at address 0
//   pix_valid   in   pixel beat valid
//   pix_data    in   {R[23:16],G[15:8],B[7:0]}
//   pix_ready   out  beat accepted when pix_valid && pix_ready
//   cea         out  port-A write enable
//   ada         out  port-A write address
//   din         out  port-A write data
//   buf_full    out  1-cycle pulse with the write to ADDRESS_DEPTH-1
//   drop_err    out  sticky: partial group discarded by frame_start
// ----------------------------------------------------------------------------
module sdpb_pixel_packer
  import sdpb_pkg::*;
#(
  parameter int ADDRESS_DEPTH = 120,
  parameter int DATA_WIDTH    = 128
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             frame_start,
  input  logic                             pix_valid,
  input  logic [23:0]                      pix_data,
  output logic                             pix_ready,
  output logic                             cea,
  output logic [$clog2(ADDRESS_DEPTH)-1:0] ada,
  output logic [DATA_WIDTH-1:0]            din,
  output logic                             buf_full,
  output logic                             drop_err
);

  localparam int PIX_PER_WORD = DATA_WIDTH / 8;
  localparam int ADDR_W       = $clog2(ADDRESS_DEPTH);
  localparam int CNT_W        = $clog2(PIX_PER_WORD);

  localparam logic [CNT_W-1:0]  LAST_PIX    = CNT_W'(PIX_PER_WORD - 1);
  localparam logic [ADDR_W-1:0] PENULT_ADDR = ADDR_W'(ADDRESS_DEPTH - 2);
  localparam logic [ADDR_W-1:0] LAST_BASE   = ADDR_W'(ADDRESS_DEPTH - CH_PER_GROUP);
  localparam logic [ADDR_W-1:0] BASE_STEP   = ADDR_W'(CH_PER_GROUP);

  wr_state_e             r_state;
  logic [CNT_W-1:0]      r_pix_cnt;
  logic [ADDR_W-1:0]     r_base;
  logic [DATA_WIDTH-1:0] r_acc [CH_PER_GROUP];
  logic [DATA_WIDTH-1:0] r_hold_g;
  logic [DATA_WIDTH-1:0] r_hold_b;
  logic                  r_cea;
  logic [ADDR_W-1:0]     r_ada;
  logic [DATA_WIDTH-1:0] r_din;
  logic                  r_buf_full;
  logic                  r_drop_err;

  rgb_t                  w_pix;
  logic [7:0]            w_chan     [CH_PER_GROUP];
  logic [DATA_WIDTH-1:0] w_acc_next [CH_PER_GROUP];
  logic                  w_ready;
  logic                  w_accept;
  logic                  w_group_done;

  assign w_pix     = rgb_t'(pix_data);
  assign w_chan[0] = w_pix.r;
  assign w_chan[1] = w_pix.g;
  assign w_chan[2] = w_pix.b;

  // New samples enter at the top byte and shift down, so after 16 beats
  // pixel 0 sits in the LSB byte.
  generate
    for (genvar gi = 0; gi < CH_PER_GROUP; gi++) begin : g_shift
      assign w_acc_next[gi] = {w_chan[gi], r_acc[gi][DATA_WIDTH-1:8]};
    end
  endgenerate

  // A group completing in WR_R/WR_G would overwrite hold words still queued
  // for the current burst; in WR_B the last hold word is already on din.
  assign w_ready      = !((r_pix_cnt == LAST_PIX) && ((r_state == WR_R) || (r_state == WR_G)));
  assign w_accept     = pix_valid && w_ready;
  // The beat coinciding with frame_start is pixel 0, so it never completes a group.
  assign w_group_done = w_accept && !frame_start && (r_pix_cnt == LAST_PIX);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= IDLE;
      r_pix_cnt  <= '0;
      r_base     <= '0;
      for (int c = 0; c < CH_PER_GROUP; c++) r_acc[c] <= '0;
      r_hold_g   <= '0;
      r_hold_b   <= '0;
      r_cea      <= 1'b0;
      r_ada      <= '0;
      r_din      <= '0;
      r_buf_full <= 1'b0;
      r_drop_err <= 1'b0;
    end else begin
      r_buf_full <= 1'b0;

      if (w_accept) begin
        for (int c = 0; c < CH_PER_GROUP; c++) r_acc[c] <= w_acc_next[c];
      end

      if (frame_start) begin
        r_pix_cnt <= w_accept ? CNT_W'(1) : '0;
        if (r_pix_cnt != '0) r_drop_err <= 1'b1;
      end else if (w_accept) begin
        r_pix_cnt <= (r_pix_cnt == LAST_PIX) ? '0 : r_pix_cnt + 1'b1;
      end

      // r_base holds the address of the next burst; it advances when a burst
      // is launched, so an in-flight burst keeps its addresses in r_ada.
      if (frame_start) begin
        r_base <= '0;
      end else if (w_group_done) begin
        r_base <= (r_base == LAST_BASE) ? '0 : r_base + BASE_STEP;
      end

      case (r_state)
        IDLE, WR_B: begin
          if (w_group_done) begin
            r_state  <= WR_R;
            r_cea    <= 1'b1;
            r_ada    <= r_base;
            r_din    <= w_acc_next[0];
            r_hold_g <= w_acc_next[1];
            r_hold_b <= w_acc_next[2];
          end else begin
            r_state <= IDLE;
            r_cea   <= 1'b0;
          end
        end
        WR_R: begin
          r_state <= WR_G;
          r_ada   <= r_ada + 1'b1;
          r_din   <= r_hold_g;
        end
        WR_G: begin
          r_state    <= WR_B;
          r_ada      <= r_ada + 1'b1;
          r_din      <= r_hold_b;
          r_buf_full <= (r_ada == PENULT_ADDR);
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign pix_ready = w_ready;
  assign cea       = r_cea;
  assign ada       = r_ada;
  assign din       = r_din;
  assign buf_full  = r_buf_full;
  assign drop_err  = r_drop_err;

endmodule

// File: tb/tb_sdpb_pixel_packer.sv
// ----------------------------------------------------------------------------
// tb_sdpb_pixel_packer
// Directed bench for sdpb_pixel_packer: port-A writes are logged at the
// falling edge and into a small model of the SDPB buffer memory, then
// compared against hand-computed words and addresses.
// ----------------------------------------------------------------------------
module tb_sdpb_pixel_packer;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         frame_start = 1'b0;
  logic         pix_valid = 1'b0;
  logic [23:0]  pix_data = '0;
  logic         pix_ready;
  logic         cea;
  logic [6:0]   ada;
  logic [127:0] din;
  logic         buf_full;
  logic         drop_err;

  int vec_cnt = 0;
  int err_cnt = 0;
  int ready_low = 0;

  logic [6:0]   q_ada [$];
  logic [127:0] q_din [$];
  logic         q_bf  [$];
  logic [127:0] mem [0:119];

  localparam logic [127:0] W1_R = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] W1_G = 128'h4F4E4D4C4B4A49484746454443424140;
  localparam logic [127:0] W1_B = 128'h8F8E8D8C8B8A89888786858483828180;
  localparam logic [127:0] W2_B = 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0;
  localparam logic [127:0] W_02 = 128'h02020202020202020202020202020202;

  sdpb_pixel_packer #(.ADDRESS_DEPTH(120), .DATA_WIDTH(128)) dut (
    .clk(clk), .resetn(resetn), .frame_start(frame_start),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .cea(cea), .ada(ada), .din(din), .buf_full(buf_full), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cea) begin
      q_ada.push_back(ada);
      q_din.push_back(din);
      q_bf.push_back(buf_full);
      if (ada < 7'd120) mem[ada] <= din;
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] wa(input int i);
    return (i < q_ada.size()) ? 128'(q_ada[i]) : '1;
  endfunction
  function automatic logic [127:0] wd(input int i);
    return (i < q_din.size()) ? q_din[i] : '1;
  endfunction
  function automatic logic [127:0] wb(input int i);
    return (i < q_bf.size()) ? 128'(q_bf[i]) : '1;
  endfunction

  function automatic logic [23:0] pix_a(input int i);
    return {8'(i), 8'(8'h40 + i), 8'(8'h80 + i)};
  endfunction
  function automatic logic [23:0] pix_b(input int i);
    return {8'(8'h20 + i), 8'(8'h60 + i), 8'(8'hA0 + i)};
  endfunction

  task automatic clear_log();
    q_ada.delete();
    q_din.delete();
    q_bf.delete();
  endtask

  task automatic send(input logic [23:0] d, input logic fs);
    bit ok = 1'b0;
    pix_valid   = 1'b1;
    pix_data    = d;
    frame_start = fs;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (pix_ready) ok = 1'b1;
      else ready_low++;
      @(posedge clk);
      #1;
    end
    pix_valid   = 1'b0;
    frame_start = 1'b0;
    if (!ok) chk("send_timeout", 128'd0, 128'd1);
  endtask

  task automatic idle(input int n);
    pix_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    pix_valid = 1'b0;
    frame_start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset values, sampled while reset is held
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cea", 128'(cea), 128'd0);
    chk("rst_ada", 128'(ada), 128'd0);
    chk("rst_din", din, 128'd0);
    chk("rst_buf_full", 128'(buf_full), 128'd0);
    chk("rst_drop_err", 128'(drop_err), 128'd0);
    chk("rst_pix_ready", 128'(pix_ready), 128'd1);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Case 1: one group, burst latency and contents
    clear_log();
    for (int i = 0; i < 16; i++) begin
      send(pix_a(i), 1'b0);
      if (i == 14) chk("c1_no_early_cea", 128'(cea), 128'd0);
    end
    chk("c1_cea_latency", 128'(cea), 128'd1);
    chk("c1_ada_first", 128'(ada), 128'd0);
    idle(5);
    chk("c1_nwrites", 128'(q_ada.size()), 128'd3);
    chk("c1_ada0", wa(0), 128'd0);
    chk("c1_ada1", wa(1), 128'd1);
    chk("c1_ada2", wa(2), 128'd2);
    chk("c1_din_r", wd(0), W1_R);
    chk("c1_din_g", wd(1), W1_G);
    chk("c1_din_b", wd(2), W1_B);
    chk("c1_bf", wb(2), 128'd0);
    // Case 6: buffer model readback
    chk("c6_mem0", mem[0], W1_R);
    chk("c6_mem1", mem[1], W1_G);
    chk("c6_mem2", mem[2], W1_B);

    // Case 2: 41 groups at one beat per cycle, wrap at address 119
    do_reset();
    clear_log();
    ready_low = 0;
    for (int n = 0; n < 656; n++) begin
      logic [15:0] nn;
      nn = 16'(n);
      send({nn[7:0], nn[15:8], 8'hA5}, 1'b0);
    end
    idle(5);
    chk("c2_ready_never_low", 128'(ready_low), 128'd0);
    chk("c2_nwrites", 128'(q_ada.size()), 128'd123);
    chk("c2_ada118", wa(118), 128'd118);
    chk("c2_bf118", wb(118), 128'd0);
    chk("c2_ada119", wa(119), 128'd119);
    chk("c2_bf119", wb(119), 128'd1);
    chk("c2_ada_wrap", wa(120), 128'd0);
    chk("c2_bf120", wb(120), 128'd0);
    chk("c2_din_wrap_r", wd(120), W1_B);
    chk("c2_din_wrap_g", wd(121), W_02);
    begin
      int bf_sum = 0;
      foreach (q_bf[k]) bf_sum += int'(q_bf[k]);
      chk("c2_bf_pulses", 128'(bf_sum), 128'd1);
    end

    // Case 3: partial group discarded by frame_start
    clear_log();
    for (int i = 0; i < 5; i++) send(24'hFFFFFF, 1'b0);
    pix_valid = 1'b0;
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    chk("c3_drop_err", 128'(drop_err), 128'd1);
    idle(3);
    chk("c3_no_write", 128'(q_ada.size()), 128'd0);
    for (int i = 0; i < 16; i++) send(pix_a(i), 1'b0);
    idle(5);
    chk("c3_nwrites", 128'(q_ada.size()), 128'd3);
    chk("c3_ada0", wa(0), 128'd0);
    chk("c3_ada2", wa(2), 128'd2);
    chk("c3_din_r", wd(0), W1_R);
    chk("c3_din_b", wd(2), W1_B);
    chk("c3_drop_sticky", 128'(drop_err), 128'd1);

    // Case 4: frame_start on beat 0 and during WR_G
    do_reset();
    clear_log();
    for (int i = 0; i < 16; i++) send(pix_a(i), i == 0);
    for (int i = 0; i < 16; i++) send(pix_b(i), 1'b0);
    idle(1);
    chk("c4_in_wr_g", 128'(ada), 128'd4);
    for (int i = 0; i < 16; i++) send(pix_a(i), i == 0);
    idle(5);
    chk("c4_nwrites", 128'(q_ada.size()), 128'd9);
    chk("c4_ada0", wa(0), 128'd0);
    chk("c4_old_ada3", wa(3), 128'd3);
    chk("c4_old_ada5", wa(5), 128'd5);
    chk("c4_old_din_b", wd(5), W2_B);
    chk("c4_new_ada6", wa(6), 128'd0);
    chk("c4_new_ada8", wa(8), 128'd2);
    chk("c4_new_din_r", wd(6), W1_R);
    chk("c4_drop_err", 128'(drop_err), 128'd0);

    // Case 5: asynchronous reset in the middle of a burst
    clear_log();
    for (int i = 0; i < 16; i++) send(pix_b(i), 1'b0);
    idle(1);
    #2;
    resetn = 1'b0;
    #1;
    chk("c5_async_cea", 128'(cea), 128'd0);
    chk("c5_async_ada", 128'(ada), 128'd0);
    chk("c5_async_din", din, 128'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    clear_log();
    for (int i = 0; i < 16; i++) send(pix_a(i), 1'b0);
    idle(5);
    chk("c5_nwrites", 128'(q_ada.size()), 128'd3);
    chk("c5_ada0", wa(0), 128'd0);
    chk("c5_ada2", wa(2), 128'd2);
    chk("c5_din_g", wd(1), W1_G);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
